// File: rtl/bus_tx_fifo_if.sv
// simple_bus link: 8-bit data with a valid/ready handshake.
// master drives data and valid toward the receiver; slave drives ready back.
// Ports (master view): data out[8], valid out, ready in.
interface bus_tx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bus_tx_fifo.sv
// Transmit FIFO: buffers locally pushed bytes and sends them on simple_bus.
// Latency: a push into an empty buffer shows bus_valid one cycle later; 1 byte/cycle sustained.
// Backpressure: data/valid are held while bus_ready=0; pushes while full are dropped.
//
// Ports: clk, rst (async, active-high); wr_en/wr_data push side; full;
//        flush (synchronous clear); bus (simple_bus master: data, valid, ready);
//        level (bytes buffered, 0..DEPTH).
// Optional: define BUS_TX_DROP_CNT_EN to add drop_cnt[15:0], a saturating
//           count of pushes rejected because the buffer was full.
module bus_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  output logic                 full,
  input  logic                 flush,
  bus_tx_fifo_if.master        bus,
`ifdef BUS_TX_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  output logic [AW:0]          level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [7:0]    last_q;
  logic [7:0]    bus_data_w;
  logic          bus_valid_w;
  logic          push;
  logic          pop;

  // Outputs come only from registered state: no path from ready/wr_* to them.
  assign bus_valid_w = (level_q != '0);
  // When empty, keep showing whatever was last presented on the bus.
  assign bus_data_w  = bus_valid_w ? mem[rd_ptr] : last_q;

  assign full      = (level_q == LVL_FULL);
  assign level     = level_q;
  assign bus.data  = bus_data_w;
  assign bus.valid = bus_valid_w;

  // Full is judged on the level at this edge; a same-cycle pop does not
  // open a slot for a push.
  assign push = wr_en & ~full;
  assign pop  = bus_valid_w & bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= 8'd0;
    end else begin
      last_q <= bus_data_w;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

`ifdef BUS_TX_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 16'd0;
    end else if (flush) begin
      drop_cnt <= 16'd0;
    end else if (wr_en && full && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_tx_fifo.sv
module tb_bus_tx_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       flush;
  logic [2:0] level;
`ifdef BUS_TX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  bus_tx_fifo_if bif ();

  bus_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .flush   (flush),
    .bus     (bif.master),
`ifdef BUS_TX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .level   (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are changed only just after a rising edge, so at the falling edge
  // they already describe what the next rising edge will do.
  always @(negedge clk) begin
    logic was_full;
    logic [7:0] e;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      was_full = (exp_q.size() == DEPTH);
      if (bif.valid && bif.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_unexpected: got %0h, expected no transfer", bif.data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", int'(bif.data), int'(e));
        end
      end
      if (wr_en && !was_full) exp_q.push_back(wr_data);
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    wr_en = w; wr_data = d; bif.ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string name, input int lvl, input int vld, input int ful);
    chk({name, "_level"}, int'(level), lvl);
    chk({name, "_valid"}, int'(bif.valid), vld);
    chk({name, "_full"},  int'(full), ful);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic       fl;
    logic [2:0] lvl;
    logic       vld;
    logic       ful;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // {wr, data, ready, flush} -> {level, valid, full, bus_data} after the edge
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 8'hA5};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'h01};
    tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'h01};
    tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01};
    tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 8'h02};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 8'h03};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 8'h04};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h04};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; bif.ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_data", int'(bif.data), 0);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk_out("idle", 0, 0, 0);
    chk("idle_data", int'(bif.data), 0);
`ifdef BUS_TX_DROP_CNT_EN
    chk("reset_drop_cnt", int'(drop_cnt), 0);
`endif

    // Single push, backpressure fill, drop while full, then drain.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].wr, tbl[i].d, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].lvl));
      chk($sformatf("vec%0d_valid", i), int'(bif.valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d_full", i),  int'(full), int'(tbl[i].ful));
      chk($sformatf("vec%0d_data", i),  int'(bif.data), int'(tbl[i].dat));
    end
`ifdef BUS_TX_DROP_CNT_EN
    chk("drop_cnt_after_table", int'(drop_cnt), 1);
`endif

    // Steady push+pop at level 2; pointers wrap several times.
    cyc(1'b1, 8'hE0, 1'b0, 1'b0);
    cyc(1'b1, 8'hE1, 1'b0, 1'b0);
    chk_out("prefill", 2, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d_level", i), int'(level), 2);
    end
    for (int i = 0; i < 8 && level != 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("stream_drained", 0, 0, 0);
    chk("stream_sb_empty", exp_q.size(), 0);

    // Asynchronous reset while holding data.
    cyc(1'b1, 8'h21, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("after_rst", 0, 0, 0);

    // Flush while full, with push and pop requested in the same cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk_out("flush_pre", 4, 1, 1);
    cyc(1'b1, 8'h34, 1'b1, 1'b1);
    chk_out("flush", 0, 0, 0);
    chk("flush_data_hold", int'(bif.data), 8'h30);
`ifdef BUS_TX_DROP_CNT_EN
    chk("flush_drop_same_cycle", int'(drop_cnt), 0);
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("flush_idle", 0, 0, 0);

`ifdef BUS_TX_DROP_CNT_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    chk("drop_cnt_3", int'(drop_cnt), 3);
    chk_out("drop_full", 4, 1, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drop_cnt_flush", int'(drop_cnt), 0);
    chk_out("drop_flushed", 0, 0, 0);
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
